// File: rtl/cic_decim_mc.sv
// -----------------------------------------------------------------------------
// cic_decim_mc
//   Multichannel N-stage CIC decimator (differential delay 1) feeding the FIR.
//   Time-interleaved input samples carry a channel index. Each channel is
//   integrated, decimated by a runtime ratio R, comb-filtered, scaled by a
//   runtime arithmetic right shift and saturated to OUTPUT_WIDTH.
//
//   Pipeline (k = accepting edge):
//     edge k   : integrator chain update, decimation counter, comb input latch
//     edge k+1 : comb chain + shift + saturate into the scale register
//     edge k+2 : output register (Data_Out / Data_Out_ChIdx / Data_Out_Valid)
//
//   Configuration is a two-word sequence: word0 = R (clamped to 2..MAX_DECIM),
//   word1[5:0] = SHIFT (clamped to ACC_WIDTH-1). The second word clears all
//   channel state and the comb input register.
//
//   Optional build macro CIC_ROUND_EN: adds 2^(SHIFT-1) before the shift
//   (round half up). Without it the shift truncates. Latency is unchanged.
//
// Ports
//   CLK, RST        clock; asynchronous active-high reset
//   isConfig        config word strobe (one cycle per word)
//   Data_Config_In  config word
//   isConfigACK     one-cycle pulse per accepted config word
//   isConfigDone    one-cycle pulse together with the second ACK
//   Data_In         signed input sample
//   Data_In_Valid   input sample qualifier
//   Data_In_ChIdx   channel of Data_In
//   Data_Out        signed decimated, scaled, saturated sample
//   Data_Out_Valid  one-cycle output qualifier
//   Data_Out_ChIdx  channel of Data_Out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cic_decim_mc #(
  parameter int INPUT_WIDTH  = 24,
  parameter int OUTPUT_WIDTH = 24,
  parameter int CIC_STAGES   = 3,
  parameter int MAX_DECIM    = 64,
  parameter int NUM_CHANNELS = 2,
  parameter int ACC_WIDTH    = 42,
  parameter int CONFIG_WIDTH = 24
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           isConfig,
  input  logic [CONFIG_WIDTH-1:0]        Data_Config_In,
  output logic                           isConfigACK,
  output logic                           isConfigDone,
  input  logic signed [INPUT_WIDTH-1:0]  Data_In,
  input  logic                           Data_In_Valid,
  input  logic [3:0]                     Data_In_ChIdx,
  output logic signed [OUTPUT_WIDTH-1:0] Data_Out,
  output logic                           Data_Out_Valid,
  output logic [3:0]                     Data_Out_ChIdx
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = $clog2(MAX_DECIM);
  localparam int R_W   = CNT_W + 1;
  localparam int SH_W  = 6;

  typedef enum logic {ST_IDLE, ST_W1} cfg_state_e;

  // ---------------------------------------------------------------------------
  // Configuration FSM
  // ---------------------------------------------------------------------------
  cfg_state_e        state_q, state_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              clear_chan;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    shift_d    = shift_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    clear_chan = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (isConfig) begin
          if (Data_Config_In < CONFIG_WIDTH'(2))
            r_d = R_W'(2);
          else if (Data_Config_In > CONFIG_WIDTH'(MAX_DECIM))
            r_d = R_W'(MAX_DECIM);
          else
            r_d = Data_Config_In[R_W-1:0];
          ack_d   = 1'b1;
          state_d = ST_W1;
        end
      end
      ST_W1: begin
        if (isConfig) begin
          if (Data_Config_In[SH_W-1:0] > SH_W'(ACC_WIDTH-1))
            shift_d = SH_W'(ACC_WIDTH-1);
          else
            shift_d = Data_Config_In[SH_W-1:0];
          ack_d      = 1'b1;
          done_d     = 1'b1;
          clear_chan = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      r_q     <= R_W'(4);
      shift_q <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      shift_q <= shift_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign isConfigACK  = ack_q;
  assign isConfigDone = done_q;

  // ---------------------------------------------------------------------------
  // Integrator chain and decimation counters (edge k)
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] integ_q [NUM_CHANNELS][CIC_STAGES];
  logic signed [ACC_WIDTH-1:0] dly_q   [NUM_CHANNELS][CIC_STAGES];
  logic [CNT_W-1:0]            cnt_q   [NUM_CHANNELS];

  logic                        accept;
  logic [CH_W-1:0]             ch_sel;
  logic                        cnt_last;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] int_d [CIC_STAGES];

  // A config strobe in the same cycle wins over the sample.
  assign accept = Data_In_Valid && !isConfig && (state_q == ST_IDLE) &&
                  ({1'b0, Data_In_ChIdx} < 5'(NUM_CHANNELS));
  assign ch_sel   = Data_In_ChIdx[CH_W-1:0];
  assign cnt_last = ({1'b0, cnt_q[ch_sel]} == (r_q - 1'b1));
  assign x_ext    = {{(ACC_WIDTH-INPUT_WIDTH){Data_In[INPUT_WIDTH-1]}}, Data_In};

  // Whole chain settles in one cycle; additions wrap modulo 2^ACC_WIDTH.
  always_comb begin
    int_d[0] = integ_q[ch_sel][0] + x_ext;
    for (int s = 1; s < CIC_STAGES; s++)
      int_d[s] = integ_q[ch_sel][s] + int_d[s-1];
  end

  // ---------------------------------------------------------------------------
  // Comb input register, comb chain, scale and saturate (edge k+1)
  // ---------------------------------------------------------------------------
  logic                           p1_v_q;
  logic signed [ACC_WIDTH-1:0]    p1_data_q;
  logic [3:0]                     p1_ch_q;
  logic [CH_W-1:0]                p1_sel;
  logic signed [ACC_WIDTH-1:0]    comb_c [CIC_STAGES];
  logic signed [ACC_WIDTH:0]      ext;
  logic signed [ACC_WIDTH:0]      rounded;
  logic signed [ACC_WIDTH:0]      shifted;
  logic [ACC_WIDTH-OUTPUT_WIDTH+1:0] hi;
  logic signed [OUTPUT_WIDTH-1:0] sat;
`ifdef CIC_ROUND_EN
  logic signed [ACC_WIDTH:0]      half;
`endif

  assign p1_sel = p1_ch_q[CH_W-1:0];

  always_comb begin
    comb_c[0] = p1_data_q - dly_q[p1_sel][0];
    for (int s = 1; s < CIC_STAGES; s++)
      comb_c[s] = comb_c[s-1] - dly_q[p1_sel][s];
    // One guard bit keeps the rounding add from overflowing.
    ext = {comb_c[CIC_STAGES-1][ACC_WIDTH-1], comb_c[CIC_STAGES-1]};
`ifdef CIC_ROUND_EN
    half    = ((ACC_WIDTH+1)'(1) << shift_q) >> 1;
    rounded = ext + half;
`else
    rounded = ext;
`endif
    shifted = rounded >>> shift_q;
    // In range when every bit above the output sign bit equals it.
    hi = shifted[ACC_WIDTH:OUTPUT_WIDTH-1];
    if (&hi || ~|hi)
      sat = shifted[OUTPUT_WIDTH-1:0];
    else if (shifted[ACC_WIDTH])
      sat = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    else
      sat = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  end

  // NOTE: channel state lives in flops rather than RAM, so it takes the async
  // reset and the synchronous config clear directly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c] <= '0;
        for (int s = 0; s < CIC_STAGES; s++) begin
          integ_q[c][s] <= '0;
          dly_q[c][s]   <= '0;
        end
      end
      p1_v_q    <= 1'b0;
      p1_data_q <= '0;
      p1_ch_q   <= '0;
    end else if (clear_chan) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c] <= '0;
        for (int s = 0; s < CIC_STAGES; s++) begin
          integ_q[c][s] <= '0;
          dly_q[c][s]   <= '0;
        end
      end
      p1_v_q    <= 1'b0;
      p1_data_q <= '0;
      p1_ch_q   <= '0;
    end else begin
      if (accept) begin
        for (int s = 0; s < CIC_STAGES; s++)
          integ_q[ch_sel][s] <= int_d[s];
        if (cnt_last) begin
          cnt_q[ch_sel] <= '0;
          p1_data_q     <= int_d[CIC_STAGES-1];
          p1_ch_q       <= Data_In_ChIdx;
        end else begin
          cnt_q[ch_sel] <= cnt_q[ch_sel] + 1'b1;
        end
      end
      p1_v_q <= accept && cnt_last;
      if (p1_v_q) begin
        dly_q[p1_sel][0] <= p1_data_q;
        for (int s = 1; s < CIC_STAGES; s++)
          dly_q[p1_sel][s] <= comb_c[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scale register (edge k+1) and output register (edge k+2)
  // ---------------------------------------------------------------------------
  logic                           p2_v_q;
  logic signed [OUTPUT_WIDTH-1:0] p2_data_q;
  logic [3:0]                     p2_ch_q;
  logic                           out_v_q;
  logic signed [OUTPUT_WIDTH-1:0] out_data_q;
  logic [3:0]                     out_ch_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p2_v_q     <= 1'b0;
      p2_data_q  <= '0;
      p2_ch_q    <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      p2_v_q  <= p1_v_q;
      out_v_q <= p2_v_q;
      if (p1_v_q) begin
        p2_data_q <= sat;
        p2_ch_q   <= p1_ch_q;
      end
      if (p2_v_q) begin
        out_data_q <= p2_data_q;
        out_ch_q   <= p2_ch_q;
      end
    end
  end

  assign Data_Out       = out_data_q;
  assign Data_Out_Valid = out_v_q;
  assign Data_Out_ChIdx = out_ch_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_mc
//   Directed bench for cic_decim_mc: reset state, DC gain, shift/rounding,
//   saturation, channel interleaving with an illegal channel, runtime
//   reconfiguration with ACK/Done handshakes, R clamping, latency, and an
//   asynchronous reset in the middle of a stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cic_decim_mc;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                isConfig = 1'b0;
  logic [23:0]         Data_Config_In = '0;
  logic                isConfigACK;
  logic                isConfigDone;
  logic signed [23:0]  Data_In = '0;
  logic                Data_In_Valid = 1'b0;
  logic [3:0]          Data_In_ChIdx = '0;
  logic signed [23:0]  Data_Out;
  logic                Data_Out_Valid;
  logic [3:0]          Data_Out_ChIdx;

  cic_decim_mc dut (
    .CLK            (CLK),
    .RST            (RST),
    .isConfig       (isConfig),
    .Data_Config_In (Data_Config_In),
    .isConfigACK    (isConfigACK),
    .isConfigDone   (isConfigDone),
    .Data_In        (Data_In),
    .Data_In_Valid  (Data_In_Valid),
    .Data_In_ChIdx  (Data_In_ChIdx),
    .Data_Out       (Data_Out),
    .Data_Out_Valid (Data_Out_Valid),
    .Data_Out_ChIdx (Data_Out_ChIdx)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Output collector, sampled on the falling edge.
  logic signed [23:0] q_data[$];
  logic [3:0]         q_ch[$];

  always @(negedge CLK) begin
    if (Data_Out_Valid === 1'b1) begin
      q_data.push_back(Data_Out);
      q_ch.push_back(Data_Out_ChIdx);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] qd(input int i);
    if (i < q_data.size()) return 64'(q_data[i]);
    return 'x;
  endfunction

  function automatic logic signed [63:0] qc(input int i);
    if (i < q_ch.size()) return {60'b0, q_ch[i]};
    return 'x;
  endfunction

  task automatic flush();
    q_data.delete();
    q_ch.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      Data_In_Valid = 1'b0;
      isConfig      = 1'b0;
    end
  endtask

  task automatic send(input logic [3:0] ch, input logic signed [23:0] d);
    @(negedge CLK);
    Data_In_Valid = 1'b1;
    Data_In_ChIdx = ch;
    Data_In       = d;
  endtask

  task automatic feed(input logic [3:0] ch, input logic signed [23:0] d, input int n);
    repeat (n) send(ch, d);
    idle(4);
  endtask

  // Two-word config; a sample is driven alongside and must be ignored.
  task automatic configure(input string tag, input logic [23:0] r, input logic [23:0] sh);
    @(negedge CLK);
    isConfig       = 1'b1;
    Data_Config_In = r;
    Data_In_Valid  = 1'b1;
    Data_In_ChIdx  = 4'd0;
    Data_In        = 24'sd77;
    @(negedge CLK);
    check({tag, ".ack1"}, isConfigACK, 1);
    check({tag, ".done1"}, isConfigDone, 0);
    Data_Config_In = sh;
    @(negedge CLK);
    check({tag, ".ack2"}, isConfigACK, 1);
    check({tag, ".done2"}, isConfigDone, 1);
    isConfig      = 1'b0;
    Data_In_Valid = 1'b0;
    @(negedge CLK);
    check({tag, ".ack_clr"}, isConfigACK, 0);
    check({tag, ".done_clr"}, isConfigDone, 0);
    flush();
  endtask

  int prof [5] = '{20, 60, 64, 64, 64};
  int r2   [5] = '{4, 8, 8, 8, 8};

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge CLK);
    check("rst.data", Data_Out, 0);
    check("rst.valid", Data_Out_Valid, 0);
    check("rst.ch", Data_Out_ChIdx, 0);
    check("rst.ack", isConfigACK, 0);
    check("rst.done", isConfigDone, 0);
    @(negedge CLK);
    RST = 1'b0;

    // ---- T1: defaults R=4 SHIFT=0, DC +1 ----
    flush();
    feed(4'd0, 24'sd1, 20);
    check("t1.count", q_data.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1.data[%0d]", i), qd(i), prof[i]);
      check($sformatf("t1.ch[%0d]", i), qc(i), 0);
    end

    // ---- T2: shift 6 and 7 ----
    configure("t2a.cfg", 24'd4, 24'd6);
    feed(4'd0, 24'sd1, 20);
    check("t2a.count", q_data.size(), 5);
    check("t2a.settled", qd(4), 1);

    configure("t2b.cfg", 24'd4, 24'd7);
    feed(4'd0, 24'sd1, 20);
`ifdef CIC_ROUND_EN
    check("t2b.settled", qd(4), 1);
`else
    check("t2b.settled", qd(4), 0);
`endif

    // ---- T3: saturation at R=64 ----
    configure("t3a.cfg", 24'd64, 24'd0);
    feed(4'd0, 24'sd8388607, 256);
    check("t3a.count", q_data.size(), 4);
    check("t3a.first", qd(0), 8388607);
    check("t3a.settled", qd(3), 8388607);

    configure("t3b.cfg", 24'd64, 24'd0);
    feed(4'd0, -24'sd8388608, 256);
    check("t3b.count", q_data.size(), 4);
    check("t3b.settled", qd(3), -8388608);

    // ---- T4: interleaved channels with illegal channel 5 ----
    configure("t4.cfg", 24'd4, 24'd0);
    for (int i = 0; i < 20; i++) begin
      send(4'd0, 24'sd1);
      send(4'd5, 24'sd1000);
      send(4'd1, -24'sd1);
    end
    idle(4);
    check("t4.count", q_data.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4.ch[%0d]", i), qc(i), i % 2);
      check($sformatf("t4.data[%0d]", i), qd(i), (i % 2 == 0) ? prof[i/2] : -prof[i/2]);
    end

    // ---- T5: mid-stream reconfiguration R=8 SHIFT=9 ----
    feed(4'd0, 24'sd1, 6);
    configure("t5.cfg", 24'd8, 24'd9);
    feed(4'd0, 24'sd1, 39);
    check("t5.count", q_data.size(), 4);
    check("t5.first", qd(0), 0);
    check("t5.third", qd(2), 1);
    check("t5.settled", qd(3), 1);

    // ---- T5b: R=0 clamps to 2; latency of two clocks ----
    configure("t5b.cfg", 24'd0, 24'd0);
    send(4'd0, 24'sd1);
    send(4'd0, 24'sd1);
    @(negedge CLK);
    Data_In_Valid = 1'b0;
    check("lat.k0.valid", Data_Out_Valid, 0);
    @(negedge CLK);
    check("lat.k1.valid", Data_Out_Valid, 0);
    @(negedge CLK);
    check("lat.k2.valid", Data_Out_Valid, 1);
    check("lat.k2.data", Data_Out, r2[0]);
    check("lat.k2.ch", Data_Out_ChIdx, 0);
    @(negedge CLK);
    check("lat.k3.valid", Data_Out_Valid, 0);
    flush();
    feed(4'd0, 24'sd1, 8);
    check("t5b.count", q_data.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5b.data[%0d]", i), qd(i), r2[i+1]);

    // ---- T6: asynchronous reset mid-stream ----
    repeat (7) send(4'd0, 24'sd1);
    @(negedge CLK);
    check("t6.pre.data", Data_Out, 8);
    RST           = 1'b1;
    Data_In_Valid = 1'b0;
    #1;
    check("t6.rst.data", Data_Out, 0);
    check("t6.rst.valid", Data_Out_Valid, 0);
    check("t6.rst.ch", Data_Out_ChIdx, 0);
    @(negedge CLK);
    RST = 1'b0;
    flush();
    feed(4'd0, 24'sd1, 20);
    check("t6.count", q_data.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t6.data[%0d]", i), qd(i), prof[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
